// File: rtl/led_pattern_if.sv
// Register-side bundle for led_pattern_engine: control inputs from the xdom
// registers plus the LED pin, step strobe and position outputs.
interface led_pattern_if #(
  parameter int N_LEDS      = 4,
  parameter int P_PWM_WIDTH = 15,
  parameter int P_SPD_WIDTH = 2
);
  localparam int POS_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;

  logic                   en;
  logic [1:0]             mode;
  logic [P_SPD_WIDTH-1:0] speed_sel;
  logic [P_PWM_WIDTH-1:0] level;
  logic [N_LEDS-1:0]      led_mask;
  logic [N_LEDS-1:0]      led_out;
  logic                   step_pulse;
  logic [POS_W-1:0]       pos;

  modport master (
    output en, mode, speed_sel, level, led_mask,
    input  led_out, step_pulse, pos
  );

  modport slave (
    input  en, mode, speed_sel, level, led_mask,
    output led_out, step_pulse, pos
  );
endinterface

// File: rtl/led_pattern_engine.sv
// N-channel PWM LED pattern engine: STATIC, SCAN, BREATHE and CHASE modes.
// Define LED_GAMMA_EN for a square-law gamma stage (adds one pipeline register).
module led_pattern_engine #(
  parameter int N_LEDS      = 4,
  parameter int P_PWM_WIDTH = 15,
  parameter int P_BASE_TICK = 2**20,
  parameter int P_SPD_WIDTH = 2,
  parameter int P_BRTH_STEP = 256
) (
  input logic          clk,
  input logic          rst_n,
  led_pattern_if.slave bus
);
  // state   | meaning
  // ST_UP   | scan heading toward N-1 / breathe envelope rising
  // ST_DOWN | scan heading toward 0   / breathe envelope falling

  localparam int W     = P_PWM_WIDTH;
  localparam int PW    = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
  localparam int PRE_W = $clog2(P_BASE_TICK) + (2**P_SPD_WIDTH);

  localparam logic [PW-1:0] POS_LAST = PW'(N_LEDS - 1);
  localparam logic [W:0]    BSTEP    = (W+1)'(P_BRTH_STEP);

  typedef enum logic [1:0] {
    M_STATIC  = 2'd0,
    M_SCAN    = 2'd1,
    M_BREATHE = 2'd2,
    M_CHASE   = 2'd3
  } mode_t;

  typedef enum logic {
    ST_UP   = 1'b0,
    ST_DOWN = 1'b1
  } dir_t;

  dir_t              state;
  mode_t             mode_q;
  logic [PW-1:0]     pos_q;
  logic [W-1:0]      envelope;
  logic [W-1:0]      pwm_cnt;
  logic [PRE_W-1:0]  presc;
  logic [N_LEDS-1:0] led_q;
  logic              step_q;

  logic              mode_chg;
  logic              step;
  logic [PRE_W-1:0]  presc_tc;
  logic [W:0]        env_sum;
  logic [W-1:0]      env_nxt;
  dir_t              brth_dir;
  logic [PW-1:0]     scan_pos;
  dir_t              scan_dir;
  logic [PW-1:0]     chase_pos;
  logic [W-1:0]      duty     [N_LEDS];
  logic [W-1:0]      duty_pwm [N_LEDS];

  assign mode_chg = (mode_t'(bus.mode) != mode_q);

  // Terminal count follows speed_sel live; >= keeps a speed-up from wrapping the counter.
  assign presc_tc = (PRE_W'(P_BASE_TICK) << bus.speed_sel) - PRE_W'(1);
  assign step     = (presc >= presc_tc);

  always_comb begin
    scan_pos = pos_q;
    scan_dir = state;
    if (N_LEDS > 1) begin
      if (state == ST_UP) begin
        if (pos_q == POS_LAST) begin
          scan_pos = POS_LAST - 1'b1;
          scan_dir = ST_DOWN;
        end else begin
          scan_pos = pos_q + 1'b1;
        end
      end else begin
        if (pos_q == '0) begin
          scan_pos = PW'(1);
          scan_dir = ST_UP;
        end else begin
          scan_pos = pos_q - 1'b1;
        end
      end
    end
  end

  assign chase_pos = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;

  // Envelope arithmetic is one bit wider so the rising sum never wraps.
  always_comb begin
    env_sum  = {1'b0, envelope} + BSTEP;
    env_nxt  = envelope;
    brth_dir = state;
    if (state == ST_UP) begin
      if (env_sum >= {1'b0, bus.level}) begin
        env_nxt  = bus.level;
        brth_dir = ST_DOWN;
      end else begin
        env_nxt = env_sum[W-1:0];
      end
    end else if (envelope > bus.level) begin
      env_nxt = bus.level;
    end else if ({1'b0, envelope} <= BSTEP) begin
      env_nxt  = '0;
      brth_dir = ST_UP;
    end else begin
      env_nxt = envelope - BSTEP[W-1:0];
    end
  end

  always_comb begin
    for (int i = 0; i < N_LEDS; i++) begin
      duty[i] = '0;
      case (mode_q)
        M_STATIC:  duty[i] = bus.level;
        M_SCAN: begin
          if (i == int'(pos_q))
            duty[i] = bus.level;
          else if ((i == int'(pos_q) + 1) || (i == int'(pos_q) - 1))
            duty[i] = bus.level >> 2;
        end
        M_BREATHE: duty[i] = envelope;
        M_CHASE: begin
          if (i == int'(pos_q))
            duty[i] = bus.level;
        end
        default:   duty[i] = '0;
      endcase
    end
  end

`ifdef LED_GAMMA_EN
  logic [2*W-1:0] duty_sq [N_LEDS];
  logic [W-1:0]   duty_g  [N_LEDS];

  always_comb begin
    for (int i = 0; i < N_LEDS; i++)
      duty_sq[i] = {{W{1'b0}}, duty[i]} * {{W{1'b0}}, duty[i]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_LEDS; i++) duty_g[i] <= '0;
    end else if (!bus.en || mode_chg) begin
      for (int i = 0; i < N_LEDS; i++) duty_g[i] <= '0;
    end else begin
      for (int i = 0; i < N_LEDS; i++) duty_g[i] <= W'(duty_sq[i] >> W);
    end
  end

  always_comb begin
    for (int i = 0; i < N_LEDS; i++) duty_pwm[i] = duty_g[i];
  end
`else
  always_comb begin
    for (int i = 0; i < N_LEDS; i++) duty_pwm[i] = duty[i];
  end
`endif

  // Disable and mode change both park the engine in its reset state for a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_UP;
      mode_q   <= M_STATIC;
      pos_q    <= '0;
      envelope <= '0;
      pwm_cnt  <= '0;
      presc    <= '0;
      led_q    <= '0;
      step_q   <= 1'b0;
    end else begin
      mode_q <= mode_t'(bus.mode);
      if (!bus.en || mode_chg) begin
        state    <= ST_UP;
        pos_q    <= '0;
        envelope <= '0;
        presc    <= '0;
        led_q    <= '0;
        step_q   <= 1'b0;
        pwm_cnt  <= bus.en ? pwm_cnt + 1'b1 : '0;
      end else begin
        pwm_cnt <= pwm_cnt + 1'b1;
        step_q  <= step;
        presc   <= step ? '0 : presc + 1'b1;
        for (int i = 0; i < N_LEDS; i++)
          led_q[i] <= (pwm_cnt < duty_pwm[i]) && bus.led_mask[i];
        if (step) begin
          case (mode_q)
            M_SCAN: begin
              pos_q <= scan_pos;
              state <= scan_dir;
            end
            M_BREATHE: begin
              envelope <= env_nxt;
              state    <= brth_dir;
            end
            M_CHASE:  pos_q <= chase_pos;
            default:  pos_q <= '0;
          endcase
        end
      end
    end
  end

  assign bus.led_out    = led_q;
  assign bus.step_pulse = step_q;
  assign bus.pos        = pos_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Scoreboard bench for led_pattern_engine (N=4, W=4, base tick 4, breathe step 4).
module tb_led_pattern_engine;
  logic clk;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   exp_q[$];
  int   cnt[4];
  int   n;

  led_pattern_if #(.N_LEDS(4), .P_PWM_WIDTH(4), .P_SPD_WIDTH(2)) bus_if ();

  led_pattern_engine #(
    .N_LEDS(4), .P_PWM_WIDTH(4), .P_BASE_TICK(4), .P_SPD_WIDTH(2), .P_BRTH_STEP(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic int sb_pop();
    if (exp_q.size() == 0) return -1;
    return exp_q.pop_front();
  endfunction

  function automatic int exp_duty(input int d);
`ifdef LED_GAMMA_EN
    return (d * d) >> 4;
`else
    return d;
`endif
  endfunction

  task automatic tick(input int k = 1);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic measure(input int len);
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    repeat (len) begin
      tick();
      for (int i = 0; i < 4; i++) cnt[i] += bus_if.led_out[i] ? 1 : 0;
    end
  endtask

  task automatic check_leds(input string tag);
    for (int i = 0; i < 4; i++) check_eq($sformatf("%s_led%0d", tag, i), cnt[i], sb_pop());
  endtask

  task automatic wait_step(output int nt);
    nt = 0;
    do begin
      tick();
      nt++;
    end while (!bus_if.step_pulse && nt < 100);
    check_eq("step_seen", int'(bus_if.step_pulse), 1);
  endtask

  initial begin
    rst_n = 1'b1;
    bus_if.en = 1'b1;
    bus_if.mode = 2'd0;
    bus_if.speed_sel = 2'd0;
    bus_if.level = 4'd4;
    bus_if.led_mask = 4'b1011;
    #2 rst_n = 1'b0;
    tick(3);
    check_eq("rst_led", int'(bus_if.led_out), 0);
    check_eq("rst_pos", int'(bus_if.pos), 0);
    check_eq("rst_step", int'(bus_if.step_pulse), 0);
    @(negedge clk) rst_n = 1'b1;

    // STATIC
    exp_q.push_back(exp_duty(4)); exp_q.push_back(exp_duty(4));
    exp_q.push_back(0);           exp_q.push_back(exp_duty(4));
    tick(20);
    measure(16);
    check_leds("static_l4");
    check_eq("static_pos", int'(bus_if.pos), 0);
    bus_if.level = 4'd0;
    for (int i = 0; i < 4; i++) exp_q.push_back(0);
    tick(20);
    measure(16);
    check_leds("static_l0");
    bus_if.level = 4'd15;
    bus_if.led_mask = 4'hF;
    for (int i = 0; i < 4; i++) exp_q.push_back(exp_duty(15));
    tick(20);
    measure(16);
    check_leds("static_l15");
    bus_if.level = 4'd8;
    for (int i = 0; i < 4; i++) exp_q.push_back(exp_duty(8));
    tick(20);
    measure(16);
    check_leds("static_l8");

    // SCAN bounce at speed 0
    bus_if.mode = 2'd1;
    tick();
    check_eq("scan_start_pos", int'(bus_if.pos), 0);
    foreach (exp_q[i]) check_eq("sb_leftover", 1, 0);
    exp_q = {1, 2, 3, 2, 1, 0, 1};
    for (int k = 0; k < 7; k++) begin
      wait_step(n);
      check_eq("scan_interval", n, 4);
      check_eq($sformatf("scan_pos%0d", k), int'(bus_if.pos), sb_pop());
    end

    // SCAN tail duty at pos=1, slowed down to hold position
    bus_if.speed_sel = 2'd3;
    bus_if.mode = 2'd3;
    tick();
    bus_if.mode = 2'd1;
    tick();
    exp_q.push_back(exp_duty(2)); exp_q.push_back(exp_duty(8));
    exp_q.push_back(exp_duty(2)); exp_q.push_back(0);
    wait_step(n);
    check_eq("scan_slow_interval", n, 32);
    check_eq("scan_slow_pos", int'(bus_if.pos), 1);
    tick(3);
    measure(16);
    check_leds("scan_tail");

    // BREATHE envelope walk, then level drop while rising
    bus_if.mode = 2'd2;
    bus_if.level = 4'd10;
    tick();
    exp_q = {4, 8, 10, 6, 2, 0, 4, 8};
    for (int k = 0; k < 8; k++) begin
      wait_step(n);
      tick(3);
      measure(16);
      check_eq($sformatf("breathe_env%0d", k), cnt[0], exp_duty(sb_pop()));
    end
    bus_if.level = 4'd5;
    exp_q = {5, 1};
    for (int k = 0; k < 2; k++) begin
      wait_step(n);
      tick(3);
      measure(16);
      check_eq($sformatf("breathe_clamp%0d", k), cnt[0], exp_duty(sb_pop()));
    end

    // CHASE, then switch to SCAN at pos=2
    bus_if.mode = 2'd3;
    bus_if.speed_sel = 2'd0;
    bus_if.level = 4'd15;
    tick();
    check_eq("chase_start_pos", int'(bus_if.pos), 0);
    exp_q = {1, 2, 3, 0, 1, 2};
    for (int k = 0; k < 6; k++) begin
      wait_step(n);
      check_eq($sformatf("chase_pos%0d", k), int'(bus_if.pos), sb_pop());
    end
    bus_if.mode = 2'd1;
    tick();
    check_eq("switch_pos", int'(bus_if.pos), 0);
    check_eq("switch_led", int'(bus_if.led_out), 0);
    exp_q = {1, 2};
    for (int k = 0; k < 2; k++) begin
      wait_step(n);
      check_eq("switch_presc", n, 4);
      check_eq($sformatf("switch_up%0d", k), int'(bus_if.pos), sb_pop());
    end

    // Disable mid-BREATHE and re-enable
    bus_if.mode = 2'd2;
    tick(11);
    bus_if.en = 1'b0;
    tick();
    check_eq("dis_led", int'(bus_if.led_out), 0);
    check_eq("dis_pos", int'(bus_if.pos), 0);
    n = 0;
    repeat (20) begin
      tick();
      n += (bus_if.step_pulse || bus_if.led_out != 0) ? 1 : 0;
    end
    check_eq("dis_quiet", n, 0);
    bus_if.speed_sel = 2'd3;
    bus_if.en = 1'b1;
    measure(16);
    check_eq("reen_env0", cnt[0], 0);
    wait_step(n);
    check_eq("reen_interval", n, 16);
    tick(3);
    measure(16);
    check_eq("reen_env4", cnt[0], exp_duty(4));

    // Asynchronous reset mid-CHASE
    bus_if.mode = 2'd3;
    bus_if.speed_sel = 2'd0;
    tick();
    wait_step(n);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_led", int'(bus_if.led_out), 0);
    check_eq("arst_pos", int'(bus_if.pos), 0);
    check_eq("arst_step", int'(bus_if.step_pulse), 0);

    check_eq("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end
endmodule
